// File: rtl/sdram_read_arbiter.sv
// Arbitrates the single 128-bit SDRAM read port among NUM_REQ requesters.
// Fixed priority (index 0 highest) with aging promotion and optional bounded locked bursts.
module sdram_read_arbiter #(
  parameter int NUM_REQ      = 3,
  parameter int ADDR_W       = 22,
  parameter int STARVE_LIMIT = 64,
  parameter int MAX_BURST    = 16
) (
  input  logic                      Clk50,
  input  logic                      reset,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ-1:0]        lock,
  input  logic [NUM_REQ*ADDR_W-1:0] addr_in,
  output logic [NUM_REQ-1:0]        gnt,
  output logic [NUM_REQ-1:0]        ack,
  output logic [127:0]              rdata,
  output logic                      busy,
  input  logic                      sdram_Wait,
  output logic                      sdram_rd,
  output logic [ADDR_W-1:0]         sdram_addr,
  input  logic                      sdram_ac,
  input  logic [127:0]              sdram_data
);

  localparam int OWN_W   = $clog2(NUM_REQ);
  localparam int BURST_W = $clog2(MAX_BURST + 1);
  localparam logic [6:0] LIMIT = 7'(STARVE_LIMIT);
  localparam logic [BURST_W-1:0] LAST_WORD = BURST_W'(MAX_BURST - 1);

  typedef enum logic [1:0] {IDLE, ISSUE, DONE} state_t;

  state_t              state, state_nxt;
  logic [OWN_W-1:0]    owner;
  logic [OWN_W-1:0]    winner;
  logic [BURST_W-1:0]  burst_cnt;
  logic [6:0]          starve_cnt [NUM_REQ];
  logic [NUM_REQ-1:0]  starving;
  logic [NUM_REQ-1:0]  owner_mask;
  logic                continue_burst;

  // Lowest requesting index wins, unless some requester has aged out, in which
  // case the lowest aged-out requester overrides the plain priority pick.
  always_comb begin
    winner = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      starving[i] = (starve_cnt[i] == LIMIT);
      if (req[i]) winner = OWN_W'(i);
    end
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (starving[i] && req[i]) winner = OWN_W'(i);
    end
  end

  assign owner_mask     = NUM_REQ'(1) << owner;
  assign continue_burst = lock[owner] && req[owner] && (burst_cnt < LAST_WORD) &&
                          !sdram_Wait && ((starving & ~owner_mask) == '0);

  always_ff @(posedge Clk50) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    sdram_rd  = 1'b0;
    busy      = 1'b0;
    ack       = '0;
    case (state)
      IDLE:  if ((req != '0) && !sdram_Wait) state_nxt = ISSUE;
      ISSUE: begin
        sdram_rd = 1'b1;
        busy     = 1'b1;
        if (sdram_ac) state_nxt = DONE;
      end
      DONE: begin
        busy      = 1'b1;
        ack       = gnt;
        state_nxt = continue_burst ? ISSUE : IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge Clk50) begin
    if (reset) begin
      owner      <= '0;
      burst_cnt  <= '0;
      gnt        <= '0;
      sdram_addr <= '0;
      rdata      <= '0;
    end else begin
      case (state)
        IDLE: if (state_nxt == ISSUE) begin
          owner      <= winner;
          sdram_addr <= addr_in[int'(winner) * ADDR_W +: ADDR_W];
          gnt        <= NUM_REQ'(1) << winner;
          burst_cnt  <= '0;
        end
        ISSUE: if (sdram_ac) rdata <= sdram_data;
        DONE: if (continue_burst) begin
          burst_cnt  <= burst_cnt + 1'b1;
          sdram_addr <= addr_in[int'(owner) * ADDR_W +: ADDR_W];
        end else begin
          gnt <= '0;
        end
        default: ;
      endcase
    end
  end

  // Aging: a requester that is asking but not owning accumulates wait cycles.
  always_ff @(posedge Clk50) begin
    for (int i = 0; i < NUM_REQ; i++) begin
      if (reset || !req[i] || gnt[i])  starve_cnt[i] <= '0;
      else if (starve_cnt[i] != LIMIT) starve_cnt[i] <= starve_cnt[i] + 7'd1;
    end
  end

endmodule

// File: tb/tb_sdram_read_arbiter.sv
// Scoreboard bench for sdram_read_arbiter: directed scenarios push expected acks,
// a monitor pops and compares whenever ack pulses.
module tb_sdram_read_arbiter;

  logic         Clk50 = 1'b0;
  logic         reset;
  logic [2:0]   req, lock;
  logic [65:0]  addr_in;
  logic [2:0]   gnt, ack;
  logic [127:0] rdata;
  logic         busy, sdram_Wait, sdram_rd, sdram_ac;
  logic [21:0]  sdram_addr;
  logic [127:0] sdram_data;

  sdram_read_arbiter #(.NUM_REQ(3), .ADDR_W(22), .STARVE_LIMIT(64), .MAX_BURST(16)) dut (
    .Clk50(Clk50), .reset(reset), .req(req), .lock(lock), .addr_in(addr_in),
    .gnt(gnt), .ack(ack), .rdata(rdata), .busy(busy), .sdram_Wait(sdram_Wait),
    .sdram_rd(sdram_rd), .sdram_addr(sdram_addr), .sdram_ac(sdram_ac), .sdram_data(sdram_data)
  );

  always #10 Clk50 = ~Clk50;

  typedef struct { logic [2:0] ack; logic [127:0] data; } exp_t;
  exp_t sb[$];
  exp_t got;

  int checks = 0, passes = 0, n;
  logic         model_en, use_fixed;
  logic [127:0] fixed_data;
  int           ac_delay, ac_cnt;
  logic [2:0]   drop_self, drop_all;
  logic         auto0, gap_pending;
  int           acks0, stop0, gap_at;

  function automatic logic [127:0] word_for(input logic [21:0] a);
    return {4{10'h155, a}};
  endfunction

  task automatic check_output(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("[TB] FAIL %s: actual=%0h required=%0h", name, act, exp);
  endtask

  task automatic tick();
    @(negedge Clk50);
    #1;
  endtask

  task automatic push(input int owner, input logic [127:0] data);
    exp_t e;
    e.ack  = 3'b001 << owner;
    e.data = data;
    sb.push_back(e);
  endtask

  task automatic apply_stimulus(input logic [2:0] r, input logic [2:0] l, input logic [65:0] a);
    addr_in = a;
    lock    = l;
    req     = r;
  endtask

  task automatic wait_drain(input string name, input int bound);
    int k = 0;
    while (sb.size() != 0 && k < bound) begin
      tick();
      k++;
    end
    check_output(name, sb.size(), 0);
    sb.delete();
  endtask

  // SDRAM controller model: answers each read after ac_delay extra ISSUE cycles.
  always @(negedge Clk50) begin
    if (model_en) begin
      if (sdram_rd) begin
        if (ac_cnt == ac_delay) begin
          sdram_ac   = 1'b1;
          sdram_data = use_fixed ? fixed_data : word_for(sdram_addr);
          ac_cnt     = 0;
        end else begin
          sdram_ac = 1'b0;
          ac_cnt++;
        end
      end else begin
        sdram_ac = 1'b0;
        ac_cnt   = 0;
      end
    end
  end

  // Requester behaviour reacting to ack: advance burst address, release requests.
  always @(negedge Clk50) begin
    if (gap_pending) begin
      check_output("burst_gap_gnt", gnt, 3'b000);
      gap_pending = 1'b0;
    end
    if (auto0 && ack[0]) begin
      acks0++;
      addr_in[21:0] = addr_in[21:0] + 22'd1;
      if (acks0 == gap_at) gap_pending = 1'b1;
      if (acks0 == stop0) begin
        req[0]  = 1'b0;
        lock[0] = 1'b0;
      end
    end
    for (int i = 0; i < 3; i++) if (ack[i] && drop_self[i]) req[i] = 1'b0;
    if ((ack & drop_all) != 3'b000) begin
      req  = 3'b000;
      lock = 3'b000;
    end
  end

  always @(negedge Clk50) begin
    if (!reset) begin
      check_output("gnt_onehot_ack_in_gnt", $onehot0(gnt) && ((ack & ~gnt) == 3'b000), 1'b1);
      if (ack != 3'b000) begin
        if (sb.size() == 0) begin
          check_output("unexpected_ack", ack, 3'b000);
        end else begin
          got = sb.pop_front();
          check_output("ack_owner", ack, got.ack);
          check_output("ack_rdata", rdata, got.data);
        end
      end
    end
  end

  initial begin
    reset = 1'b1; req = '0; lock = '0; addr_in = '0; sdram_Wait = 1'b0;
    sdram_ac = 1'b0; sdram_data = '0; model_en = 1'b1; use_fixed = 1'b0;
    fixed_data = '0; ac_delay = 0; ac_cnt = 0; drop_self = '0; drop_all = '0;
    auto0 = 1'b0; gap_pending = 1'b0; acks0 = 0; stop0 = 0; gap_at = 0;
    repeat (3) tick();
    check_output("reset_gnt", gnt, 3'b000);
    check_output("reset_ack", ack, 3'b000);
    check_output("reset_rd", sdram_rd, 1'b0);
    check_output("reset_busy", busy, 1'b0);
    check_output("reset_addr", sdram_addr, 22'h0);
    check_output("reset_rdata", rdata, 128'h0);
    reset = 1'b0;
    tick();

    // Single read from requester 1 with a slow controller.
    use_fixed = 1'b1; fixed_data = {16{8'hA5}}; ac_delay = 4; drop_self = 3'b010;
    push(1, {16{8'hA5}});
    apply_stimulus(3'b010, 3'b000, {22'h0, 22'h000123, 22'h0});
    tick();
    check_output("t1_rd_latency", sdram_rd, 1'b1);
    check_output("t1_gnt", gnt, 3'b010);
    check_output("t1_addr", sdram_addr, 22'h000123);
    check_output("t1_busy", busy, 1'b1);
    n = 0;
    while (!sdram_ac && n < 20) begin
      tick();
      n++;
    end
    check_output("t1_ac_seen", sdram_ac, 1'b1);
    check_output("t1_addr_held", sdram_addr, 22'h000123);
    tick();
    check_output("t1_ack", ack, 3'b010);
    check_output("t1_rdata", rdata, {16{8'hA5}});
    check_output("t1_rd_low_done", sdram_rd, 1'b0);
    tick();
    check_output("t1_gnt_release", gnt, 3'b000);
    wait_drain("t1_drain", 20);
    use_fixed = 1'b0; drop_self = 3'b000;
    repeat (2) tick();

    // Three-way contention, no locks: strict priority order.
    ac_delay = 1; drop_self = 3'b111;
    push(0, word_for(22'h10)); push(1, word_for(22'h11)); push(2, word_for(22'h12));
    apply_stimulus(3'b111, 3'b000, {22'h12, 22'h11, 22'h10});
    tick();
    check_output("t2_first_gnt", gnt, 3'b001);
    wait_drain("t2_drain", 60);
    drop_self = 3'b000;
    repeat (2) tick();

    // Locked burst capped at 16 words, then re-arbitrated from address 16.
    ac_delay = 0; auto0 = 1'b1; acks0 = 0; stop0 = 17; gap_at = 16;
    for (int k = 0; k <= 16; k++) push(0, word_for(22'(k)));
    apply_stimulus(3'b001, 3'b001, 66'h0);
    wait_drain("t3_drain", 200);
    auto0 = 1'b0;
    repeat (3) tick();

    // Starvation: index 2 ages out during index 0's second burst (after 5 words).
    ac_delay = 1; auto0 = 1'b1; acks0 = 0; stop0 = 0; gap_at = 0; drop_all = 3'b100;
    for (int k = 0; k < 21; k++) push(0, word_for(22'(k)));
    push(2, word_for(22'h2000));
    apply_stimulus(3'b101, 3'b001, {22'h2000, 22'h0, 22'h0});
    wait_drain("t4_drain", 300);
    auto0 = 1'b0; drop_all = 3'b000;
    repeat (3) tick();

    // Backpressure, then reset in the middle of a read.
    model_en = 1'b0; sdram_ac = 1'b0; sdram_Wait = 1'b1;
    apply_stimulus(3'b001, 3'b000, {22'h0, 22'h0, 22'h55});
    repeat (3) begin
      tick();
      check_output("t5_wait_rd", sdram_rd, 1'b0);
      check_output("t5_wait_gnt", gnt, 3'b000);
    end
    sdram_Wait = 1'b0;
    tick();
    check_output("t5_issue_rd", sdram_rd, 1'b1);
    check_output("t5_issue_gnt", gnt, 3'b001);
    reset = 1'b1;
    tick();
    check_output("t5_reset_rd", sdram_rd, 1'b0);
    check_output("t5_reset_gnt", gnt, 3'b000);
    check_output("t5_reset_ack", ack, 3'b000);
    check_output("t5_reset_busy", busy, 1'b0);
    reset = 1'b0; req = 3'b000;
    tick();
    sdram_ac = 1'b1; sdram_data = {8{16'hDEAD}};
    tick();
    sdram_ac = 1'b0;
    tick();
    check_output("t5_late_ac_ack", ack, 3'b000);
    check_output("t5_late_ac_rdata", rdata, 128'h0);
    check_output("t5_idle_busy", busy, 1'b0);
    repeat (2) tick();

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/sdram_read_arbiter.md
Name: sdram_read_arbiter

Overview:
Shares the single 128-bit SDRAM read port among NUM_REQ requesters: the I2S audio refill engine on index 0, plus video and sprite fetchers on higher indices. Each grant covers one 128-bit word; an optional lock extends ownership into a bounded burst. Lower index has higher priority, and an aging counter keeps lower-priority requesters from starving. The block sits between the requesters and the SDRAM controller's rd/Wait/ac handshake.

Parameters:
NUM_REQ, 3, number of requesters (2..4)
ADDR_W, 22, SDRAM word address width
STARVE_LIMIT, 64, wait cycles after which a pending requester is promoted
MAX_BURST, 16, maximum consecutive words per ownership while locked

Ports:
Clk50  in  1  system clock; all logic on posedge
reset  in  1  synchronous, active-high
req  in  NUM_REQ  per-requester read request, level
lock  in  NUM_REQ  per-requester request to keep ownership after the current word
addr_in  in  NUM_REQ*ADDR_W  packed request addresses; slice i = addr_in[i*ADDR_W +: ADDR_W]
gnt  out  NUM_REQ  one-hot current owner, or all zero
ack  out  NUM_REQ  one-cycle pulse: word for owner is on rdata
rdata  out  128  last word returned; broadcast to all requesters
busy  out  1  high in ISSUE and DONE
sdram_Wait  in  1  SDRAM controller not ready to accept a read
sdram_rd  out  1  read request to the SDRAM controller
sdram_addr  out  ADDR_W  read address to the SDRAM controller
sdram_ac  in  1  controller has data; sdram_data valid this cycle
sdram_data  in  128  read data

Behaviour:
- Reset: state IDLE; gnt, ack, sdram_rd, busy = 0; sdram_addr, rdata = 0; owner, burst_cnt, all starve counters = 0. Reset mid-transaction aborts it: sdram_rd is low the cycle after reset, and no ack is issued.
- The FSM has three states: IDLE, ISSUE, DONE.
- IDLE, entered only when req != 0 and sdram_Wait = 0:
  - Winner is the lowest index with starve_cnt == STARVE_LIMIT and req set.
  - If no such index, winner is the lowest index with req set.
  - Register owner and sdram_addr from that slice of addr_in.
  - Set gnt[owner], clear burst_cnt, go to ISSUE.
  - Latency: req rising at edge t gives sdram_rd = 1 and gnt visible after edge t+1.
- ISSUE: sdram_rd = 1 and sdram_addr is held stable. On sdram_ac, register rdata <= sdram_data and go to DONE. sdram_rd is low in DONE.
- DONE: ack[owner] = 1 for exactly one cycle. Then:
  - Continue the burst if all hold: lock[owner] && req[owner] && burst_cnt < MAX_BURST-1 && sdram_Wait = 0 && no other requester at STARVE_LIMIT. Then burst_cnt++, reload sdram_addr from addr_in[owner], go to ISSUE.
  - Otherwise clear gnt and go to IDLE.
- Requesters hold addr constant while req is high and must present the next address in the ack cycle when bursting.
- If req drops during ISSUE, the word still completes and ack still pulses; the burst does not continue.
- sdram_ac in IDLE or DONE is ignored; rdata is unchanged.
- Starve counters, per index i, 7-bit, saturating at STARVE_LIMIT:
  - Increment when req[i] && !gnt[i].
  - Clear when gnt[i] is set or req[i] = 0.
- Simultaneous requests with none starving: index 0 wins.
- Simultaneous starvation: the lowest starving index wins.
- gnt is always one-hot or zero. ack is only ever set on the index whose gnt is set.

Test Plan:
1. Single read: req[1] = 1, addr slice 1 = 0x000123, sdram_Wait = 0, sdram_ac 4 cycles after sdram_rd, sdram_data = 0xA5..A5 -> sdram_rd high one cycle after req; sdram_addr = 0x000123; ack[1] one cycle after sdram_ac; rdata = 0xA5..A5; gnt returns to 0.
2. Contention: req = 3'b111 from IDLE -> grant order is 0, 1, 2, each with a single ack; gnt is never multi-hot.
3. Locked burst: req[0] = lock[0] = 1, addresses 0..19 incrementing -> 16 acks to index 0, sdram_addr 0..15; then gnt drops for at least one IDLE cycle and index 0 is re-granted from address 16.
4. Starvation: index 0 continuously requesting and locked, req[2] held high -> after 64 cycles waiting, index 2 takes the next arbitration; its starve counter clears on grant.
5. Backpressure and reset: sdram_Wait = 1 with req[0] = 1 -> no sdram_rd and gnt = 0. Release Wait, then assert reset during ISSUE -> next cycle sdram_rd = 0, gnt = 0, ack = 0; a later sdram_ac is ignored.
